// File: rtl/uart_tx_if.sv
// Producer-to-transmitter byte handshake: TX_VALIDi/TX_DATAi from the producer, TX_READYo back.
// No storage; signals pass straight through.
// The producer holds TX_VALIDi/TX_DATAi until it sees TX_READYo high at a rising edge.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  TX_VALIDi;
  logic [DATA_WIDTH-1:0] TX_DATAi;
  logic                  TX_READYo;

  modport master (output TX_VALIDi, output TX_DATAi, input TX_READYo);
  modport slave  (input TX_VALIDi, input TX_DATAi, output TX_READYo);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8N1/8N2 frames (8E1/8O1 and 2-stop variants when UART_TX_PARITY_EN is defined).
// The start bit appears on TXo from the cycle after the handshake. DONEo is high in the final frame cycle.
// TX_READYo is high only in IDLE. Input is ignored for the whole frame, plus one idle cycle between frames.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       CLK,
  input  logic       RST,
  uart_tx_if.slave   tx_if,
  output logic       TXo,
  output logic       BUSYo,
  output logic       DONEo
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE_LAST  = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 1);

  // Reject parameter values the frame logic cannot represent.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_bit_end;
  logic                  w_accept;

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign w_accept  = (r_state == S_IDLE) && tx_if.TX_VALIDi;

`ifdef UART_TX_PARITY_EN
  logic r_par;

  // Parity is taken from the byte as latched, before any shifting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           r_par <= 1'b0;
    else if (w_accept) r_par <= (^tx_if.TX_DATAi) ^ 1'(PARITY_ODD);
  end
`endif

  // State, counters and line outputs all advance together from the next-state logic.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Frame sequencing. r_idx counts data bits in DATA and stop bits in STOP.
  // TXo is computed from the next state so that it is registered and aligned with the state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
    w_tx_nxt    = 1'b1;

    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
          w_shift_nxt = tx_if.TX_DATAi;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_idx == IDX_DATA_LAST) begin
            w_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        // DONEo is raised one cycle early so that its register lines up with the final stop cycle.
        if (r_idx == IDX_STOP_LAST && r_cnt == CNT_PRE_LAST) w_done_nxt = 1'b1;
        if (w_bit_end) begin
          if (r_idx == IDX_STOP_LAST) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = r_par;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  assign TXo             = r_tx;
  assign DONEo           = r_done;
  assign BUSYo           = (r_state != S_IDLE);
  assign tx_if.TX_READYo = (r_state == S_IDLE);

endmodule
